// File: rtl/gen3_scrambler_ctrl.sv
// gen3_scrambler_ctrl: per-lane sequencer for the Gen3 128b/130b scrambler LFSR.
// Tracks 4-word block boundaries, classifies each block from its sync header and
// first symbol, drives LFSR advance/seed-load, and applies the LFSR word to TX data
// with one cycle of latency.
// Optional build macro: SCRAMBLER_CTRL_STATS_EN adds saturating blk_cnt/err_cnt outputs.
module gen3_scrambler_ctrl #(
   parameter int LANE_NUM  = 0,
   parameter int BLK_WORDS = 4
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_start_block,
   input  logic [1:0]  in_sync_hdr,
   input  logic [31:0] in_data,
   input  logic        bypass,
   input  logic [31:0] lfsr_word,
   output logic        lfsr_advance,
   output logic        lfsr_seed_load,
   output logic [23:0] lfsr_seed,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_start_block,
   output logic [1:0]  out_sync_hdr,
   output logic [31:0] out_data,
   output logic        err_pulse
`ifdef SCRAMBLER_CTRL_STATS_EN
   ,
   output logic [15:0] blk_cnt,
   output logic [7:0]  err_cnt
`endif
);

   localparam logic [1:0] LAST_WORD = 2'(BLK_WORDS - 1);

   typedef enum logic [2:0] {
      ST_SEED,
      ST_IDLE,
      ST_DATA,
      ST_OS,
      ST_SKP,
      ST_EIEOS
   } state_t;

   // Lane seed table, indexed by lane modulo 8
   function automatic logic [23:0] seed_of(input int lane);
      case (lane % 8)
         0:       seed_of = 24'h1DBFBC;
         1:       seed_of = 24'h0607BB;
         2:       seed_of = 24'h1EC760;
         3:       seed_of = 24'h18C0DB;
         4:       seed_of = 24'h010F12;
         5:       seed_of = 24'h19CFC9;
         6:       seed_of = 24'h0277CE;
         default: seed_of = 24'h1BB807;
      endcase
   endfunction

   // Block type from sync header and first symbol; illegal headers fall back to SKP
   function automatic state_t start_type(input logic [1:0] hdr, input logic [7:0] byte0);
      case (hdr)
         2'b10:   start_type = ST_DATA;
         2'b01: begin
            if (byte0 == 8'hAA)      start_type = ST_SKP;
            else if (byte0 == 8'h00) start_type = ST_EIEOS;
            else                     start_type = ST_OS;
         end
         default: start_type = ST_SKP;
      endcase
   endfunction

   state_t      state, state_nxt, blk_type;
   logic [1:0]  word_cnt, word_cnt_nxt, word_idx;
   logic        bypass_p1;
   logic        seed_fall;
   logic        acc;
   logic        err_now;
   logic        blk_done;
   logic        adv_en;
   logic        eieos_seed;
   logic [31:0] mask;

   logic        vld_p1;
   logic        start_p1;
   logic [1:0]  hdr_p1;
   logic [31:0] data_p1;
   logic        err_p1;

   assign lfsr_seed = seed_of(LANE_NUM);
   assign seed_fall = bypass_p1 & ~bypass;
   assign in_ready  = ~reset & (state != ST_SEED) & ~seed_fall & (out_ready | ~vld_p1);
   assign acc       = in_valid & in_ready;

   // Next-state, word position and block type governing the word being accepted
   always_comb begin
      state_nxt    = state;
      word_cnt_nxt = word_cnt;
      blk_type     = state;
      word_idx     = word_cnt;
      err_now      = 1'b0;
      blk_done     = 1'b0;
      if (state == ST_SEED) begin
         state_nxt    = ST_IDLE;
         word_cnt_nxt = 2'd0;
      end else if (acc) begin
         if (in_start_block) begin
            // A start always opens a new block; an unfinished one is abandoned
            blk_type     = start_type(in_sync_hdr, in_data[7:0]);
            word_idx     = 2'd0;
            err_now      = (in_sync_hdr == 2'b00) | (in_sync_hdr == 2'b11) | (word_cnt != 2'd0);
            state_nxt    = blk_type;
            word_cnt_nxt = 2'd1;
         end else if (state == ST_IDLE) begin
            // Stray word outside a block: pass through untouched
            err_now = 1'b1;
         end else if (word_cnt == LAST_WORD) begin
            state_nxt    = ST_IDLE;
            word_cnt_nxt = 2'd0;
            blk_done     = 1'b1;
         end else begin
            word_cnt_nxt = 2'(word_cnt + 2'd1);
         end
      end
   end

   // Scramble mask and LFSR control for the current word
   always_comb begin
      mask   = 32'h0;
      adv_en = 1'b0;
      if (!bypass) begin
         case (blk_type)
            ST_DATA: begin
               mask   = lfsr_word;
               adv_en = 1'b1;
            end
            ST_OS: begin
               // First symbol of an ordered set identifies it and stays in the clear
               mask   = (word_idx == 2'd0) ? {lfsr_word[31:8], 8'h00} : lfsr_word;
               adv_en = 1'b1;
            end
            default: begin
               mask   = 32'h0;
               adv_en = 1'b0;
            end
         endcase
      end
      eieos_seed     = acc & ~bypass & (blk_type == ST_EIEOS) & (word_idx == LAST_WORD);
      lfsr_seed_load = ~reset & (((state == ST_SEED) & ~bypass) | seed_fall | eieos_seed);
      lfsr_advance   = acc & adv_en & ~lfsr_seed_load;
   end

   // Control state: FSM, word counter and bypass edge detector
   always_ff @(posedge pclk) begin
      if (reset) begin
         state     <= ST_SEED;
         word_cnt  <= 2'd0;
         bypass_p1 <= 1'b0;
      end else begin
         state     <= state_nxt;
         word_cnt  <= word_cnt_nxt;
         bypass_p1 <= bypass;
      end
   end

   // Output stage: capture on accept, hold while downstream stalls
   always_ff @(posedge pclk) begin
      if (reset) begin
         vld_p1   <= 1'b0;
         start_p1 <= 1'b0;
         hdr_p1   <= 2'b00;
         data_p1  <= 32'h0;
         err_p1   <= 1'b0;
      end else begin
         err_p1 <= acc & err_now;
         if (acc) begin
            vld_p1   <= 1'b1;
            start_p1 <= in_start_block;
            data_p1  <= in_data ^ mask;
            if (in_start_block) hdr_p1 <= in_sync_hdr;
         end else if (out_ready) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign out_valid       = vld_p1;
   assign out_start_block = start_p1;
   assign out_sync_hdr    = hdr_p1;
   assign out_data        = data_p1;
   assign err_pulse       = err_p1;

`ifdef SCRAMBLER_CTRL_STATS_EN
   // Saturating counts of completed blocks and error pulses
   always_ff @(posedge pclk) begin
      if (reset) begin
         blk_cnt <= 16'd0;
         err_cnt <= 8'd0;
      end else begin
         if (blk_done && (blk_cnt != 16'hFFFF)) blk_cnt <= blk_cnt + 16'd1;
         if (err_p1 && (err_cnt != 8'hFF))      err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gen3_scrambler_ctrl.sv
// tb_gen3_scrambler_ctrl: scoreboard bench for gen3_scrambler_ctrl (LANE_NUM=2).
// Expected output words are queued on accept and popped when the DUT hands them off.
module tb_gen3_scrambler_ctrl;

   localparam int K_DATA = 0;
   localparam int K_OS   = 1;
   localparam int K_PASS = 2;

   logic        pclk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_start_block;
   logic [1:0]  in_sync_hdr;
   logic [31:0] in_data;
   logic        bypass;
   logic [31:0] lfsr_word;
   logic        lfsr_advance;
   logic        lfsr_seed_load;
   logic [23:0] lfsr_seed;
   logic        out_valid;
   logic        out_ready;
   logic        out_start_block;
   logic [1:0]  out_sync_hdr;
   logic [31:0] out_data;
   logic        err_pulse;
`ifdef SCRAMBLER_CTRL_STATS_EN
   logic [15:0] blk_cnt;
   logic [7:0]  err_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int adv_cnt = 0;
   int sl_cnt = 0;
   int err_seen = 0;
   logic [1:0]  cur_hdr = 2'b00;
   logic [34:0] sb[$];

   gen3_scrambler_ctrl #(.LANE_NUM(2), .BLK_WORDS(4)) dut (
      .pclk(pclk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_start_block(in_start_block),
      .in_sync_hdr(in_sync_hdr),
      .in_data(in_data),
      .bypass(bypass),
      .lfsr_word(lfsr_word),
      .lfsr_advance(lfsr_advance),
      .lfsr_seed_load(lfsr_seed_load),
      .lfsr_seed(lfsr_seed),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_start_block(out_start_block),
      .out_sync_hdr(out_sync_hdr),
      .out_data(out_data),
      .err_pulse(err_pulse)
`ifdef SCRAMBLER_CTRL_STATS_EN
      ,
      .blk_cnt(blk_cnt),
      .err_cnt(err_cnt)
`endif
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input int kind, input int idx,
                                         input logic [31:0] d, input logic [31:0] l);
      case (kind)
         K_DATA:  model = d ^ l;
         K_OS:    model = (idx == 0) ? {d[31:8] ^ l[31:8], d[7:0]} : (d ^ l);
         default: model = d;
      endcase
   endfunction

   // Output monitor: counts LFSR controls / errors and checks handed-off words
   always @(negedge pclk) begin
      adv_cnt  += int'(lfsr_advance);
      sl_cnt   += int'(lfsr_seed_load);
      err_seen += int'(err_pulse);
      if (out_valid && out_ready) begin
         if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
         else                chk("out_word", 64'({out_start_block, out_sync_hdr, out_data}),
                                 64'(sb.pop_front()));
      end
   end

   // Offer one word, wait (bounded) for accept, queue its expected output
   task automatic xfer(input logic s, input logic [1:0] h, input logic [31:0] d,
                       input logic [31:0] e);
      bit got = 0;
      in_valid       = 1'b1;
      in_start_block = s;
      in_sync_hdr    = h;
      in_data        = d;
      for (int k = 0; k < 20; k++) begin
         @(negedge pclk);
         if (in_ready) begin
            got = 1;
            break;
         end
         @(posedge pclk); #1;
      end
      if (!got) begin
         chk("accept_timeout", 64'd0, 64'd1);
      end else begin
         if (s) cur_hdr = h;
         sb.push_back({s, cur_hdr, e});
         @(posedge pclk); #1;
      end
      in_valid       = 1'b0;
      in_start_block = 1'b0;
   endtask

   task automatic blk(input logic [1:0] h, input int kind, input int n, input logic [31:0] w0);
      logic [31:0] d;
      for (int i = 0; i < n; i++) begin
         d = (i == 0) ? w0 : $urandom;
         xfer(i == 0, h, d, model(kind, i, d, lfsr_word));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   initial begin
      logic [31:0] d0;
      int e0;
      reset = 1'b1; in_valid = 1'b0; in_start_block = 1'b0; in_sync_hdr = 2'b00;
      in_data = 32'h0; bypass = 1'b0; lfsr_word = 32'hA5A5A5A5; out_ready = 1'b1;

      // 1: reset state and single seed load after release
      repeat (3) @(posedge pclk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_seed_load", 64'(lfsr_seed_load), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("lfsr_seed", 64'(lfsr_seed), 64'h1EC760);
      reset = 1'b0; sl_cnt = 0;
      idle(4);
      chk("post_rst_seed_loads", 64'(sl_cnt), 64'd1);

      // 2: data block of zeros
      adv_cnt = 0;
      for (int i = 0; i < 4; i++) xfer(i == 0, 2'b10, 32'h0, 32'hA5A5A5A5);
      idle(2);
      chk("data_adv", 64'(adv_cnt), 64'd4);

      // 3: SKP passthrough, then data block
      adv_cnt = 0;
      blk(2'b01, K_PASS, 4, 32'h123456AA);
      idle(2);
      chk("skp_adv", 64'(adv_cnt), 64'd0);
      blk(2'b10, K_DATA, 4, $urandom);
      idle(2);
      chk("data2_adv", 64'(adv_cnt), 64'd4);

      // 4: EIEOS reseeds on word 3; TS1 keeps first symbol clear
      lfsr_word = 32'h3C960F5A;
      adv_cnt = 0; sl_cnt = 0;
      blk(2'b01, K_PASS, 4, 32'hFFFFFF00);
      idle(2);
      chk("eieos_adv", 64'(adv_cnt), 64'd0);
      chk("eieos_seed_load", 64'(sl_cnt), 64'd1);
      blk(2'b01, K_OS, 4, 32'h4A4A4A1E);
      idle(2);
      chk("ts1_adv", 64'(adv_cnt), 64'd4);

      // 5: early start (abandon) and illegal header
      adv_cnt = 0; e0 = err_seen;
      blk(2'b10, K_DATA, 2, $urandom);
      blk(2'b10, K_DATA, 4, $urandom);
      idle(2);
      chk("abandon_err", 64'(err_seen - e0), 64'd1);
      chk("abandon_adv", 64'(adv_cnt), 64'd6);
      adv_cnt = 0;
      blk(2'b11, K_PASS, 4, $urandom);
      idle(2);
      chk("badhdr_err", 64'(err_seen - e0), 64'd2);
      chk("badhdr_adv", 64'(adv_cnt), 64'd0);
`ifdef SCRAMBLER_CTRL_STATS_EN
      chk("stat_err_cnt", 64'(err_cnt), 64'd2);
      chk("stat_blk_cnt", 64'(blk_cnt), 64'd7);
`endif
      d0 = $urandom;
      xfer(1'b0, cur_hdr, d0, d0);
      idle(2);
      chk("idle_word_err", 64'(err_seen - e0), 64'd3);

      // 5: downstream stall holds output and LFSR
      d0 = $urandom;
      xfer(1'b1, 2'b10, d0, d0 ^ lfsr_word);
      out_ready = 1'b0; adv_cnt = 0;
      in_valid = 1'b1; in_start_block = 1'b0; in_data = $urandom;
      for (int c = 0; c < 5; c++) begin
         @(negedge pclk);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk("stall_out_valid", 64'(out_valid), 64'd1);
         chk("stall_out_data", 64'(out_data), 64'(d0 ^ lfsr_word));
      end
      @(posedge pclk); #1;
      chk("stall_adv", 64'(adv_cnt), 64'd0);
      out_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         d0 = $urandom;
         xfer(1'b0, 2'b10, d0, d0 ^ lfsr_word);
      end
      idle(2);
      chk("post_stall_adv", 64'(adv_cnt), 64'd3);

      // 6: bypass passthrough and 1->0 reseed cycle
      bypass = 1'b1; adv_cnt = 0; sl_cnt = 0;
      idle(1);
      blk(2'b10, K_PASS, 4, $urandom);
      idle(2);
      chk("bypass_adv", 64'(adv_cnt), 64'd0);
      chk("bypass_seed_load", 64'(sl_cnt), 64'd0);
      bypass = 1'b0;
      @(negedge pclk);
      chk("unbypass_seed_load", 64'(lfsr_seed_load), 64'd1);
      chk("unbypass_in_ready", 64'(in_ready), 64'd0);
      @(negedge pclk);
      chk("unbypass_seed_once", 64'(lfsr_seed_load), 64'd0);
      chk("unbypass_ready_back", 64'(in_ready), 64'd1);
      @(posedge pclk); #1;

      // 6: reset in the middle of a block
      blk(2'b10, K_DATA, 2, $urandom);
      reset = 1'b1;
      idle(2);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_data", 64'(out_data), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      sb.delete();
      reset = 1'b0; sl_cnt = 0; adv_cnt = 0;
      idle(3);
      chk("midrst_seed_load", 64'(sl_cnt), 64'd1);
      blk(2'b10, K_DATA, 4, $urandom);
      idle(2);
      chk("recover_adv", 64'(adv_cnt), 64'd4);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
